// File: rtl/input_sram_stream_reader.sv
// Read-side burst initiator for the input-activation SRAM controller: one read in flight
// at a time, returned words buffered in a small prefetch FIFO and streamed out valid/ready.
module input_sram_stream_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 12288,
    parameter int LEN_W      = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [13:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [31:0]      r_addr,
    output logic             r_en,
    input  logic             d_ready,
    input  logic [127:0]     r_d,
    output logic             w_en,
    output logic [31:0]      w_addr,
    output logic [127:0]     w_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = ((LEN_W > 14) ? LEN_W : 14) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [13:0]      ADDR_ONE  = 14'd1;
    localparam logic [SUM_W-1:0] MAX_SUM   = SUM_W'(MAX_WORDS);

    logic [1:0]       state_q, state_d;
    logic [13:0]      next_addr_q, next_addr_d;
    logic [13:0]      r_addr_q, r_addr_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] to_consume_q, to_consume_d;
    logic             r_en_q, r_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Each entry carries the last-word tag in bit 128 above the data word.
    logic [128:0]     fifo_mem [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic [SUM_W-1:0] end_addr;

    assign end_addr = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign push     = (state_q == ST_WAIT) && d_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        r_addr_d     = r_addr_q;
        remaining_d  = remaining_q;
        to_consume_d = to_consume_q;
        r_en_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        if (pop) begin
            to_consume_d = to_consume_q - LEN_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (end_addr > MAX_SUM) begin
                        err_d = 1'b1;
                    end else begin
                        next_addr_d  = cmd_addr;
                        remaining_d  = cmd_len;
                        to_consume_d = cmd_len;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Nothing is ever in flight while in ISSUE, so occupancy alone is the credit test.
                if (count_q < DEPTH_CNT) begin
                    r_en_d   = 1'b1;
                    r_addr_d = next_addr_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (d_ready) begin
                    next_addr_d = next_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - LEN_ONE;
                    state_d     = (remaining_q == LEN_ONE) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if ((count_q == '0) && (to_consume_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            next_addr_q  <= '0;
            r_addr_q     <= '0;
            remaining_q  <= '0;
            to_consume_q <= '0;
            r_en_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            r_addr_q     <= r_addr_d;
            remaining_q  <= remaining_d;
            to_consume_q <= to_consume_d;
            r_en_q       <= r_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {(remaining_q == LEN_ONE), r_d};
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign r_en      = r_en_q;
    assign r_addr    = {18'd0, r_addr_q};
    assign done      = done_q;
    assign err       = err_q;
    assign out_valid = (count_q != '0);
    assign out_data  = fifo_mem[rd_ptr_q][127:0];
    assign out_last  = out_valid && fifo_mem[rd_ptr_q][128];
    assign w_en      = 1'b0;
    assign w_addr    = 32'd0;
    assign w_d       = 128'd0;

endmodule

// File: doc/input_sram_stream_reader.md
Name: input_sram_stream_reader

Overview:
Read-side initiator for the input-activation SRAM controller. It accepts a burst command (base word address, word count) and issues one read at a time on the controller's r_en/r_addr/d_ready handshake. Returned 128-bit words are buffered in a small prefetch FIFO and streamed to the PE-array feeder over a valid/ready interface. The block never writes: w_en is tied low and w_addr/w_d are driven zero.

Parameters:
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2)
MAX_WORDS, 12288, addressable words (6 banks x 2048); bursts crossing this limit are rejected
LEN_W, 14, width of burst length/count fields

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  high in IDLE only
cmd_addr  in  14  first word address ({bank[13:11], row[10:0]})
cmd_len  in  LEN_W  number of words in the burst
r_addr  out  32  read address to controller; bits [31:14] are zero
r_en  out  1  read request pulse to controller
d_ready  in  1  one-cycle pulse from controller, r_d valid in that cycle
r_d  in  128  read data from controller
w_en  out  1  constant 0
w_addr  out  32  constant 0
w_d  out  128  constant 0
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts the head when out_valid && out_ready
out_data  out  128  FIFO head data
out_last  out  1  head is the final word of the burst
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse after the last word of the burst is consumed
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (async): state=IDLE. r_en=0, r_addr=0, FIFO empty, out_valid=0, out_last=0, done=0, err=0, busy=0, cmd_ready=1, all counters 0.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - cmd_valid && cmd_ready with cmd_len==0 -> done pulses the next cycle; state stays IDLE.
  - cmd_addr+cmd_len > MAX_WORDS (sum computed at LEN_W+1 bits) -> err pulses the next cycle; state stays IDLE; no reads are issued.
  - Otherwise latch next_addr=cmd_addr, remaining=cmd_len, to_consume=cmd_len, then go to ISSUE.
- ISSUE: entered only if FIFO occupancy plus outstanding requests < FIFO_DEPTH; otherwise wait here without asserting r_en. On issue, r_en=1 for exactly one cycle with r_addr=next_addr, then go to WAIT.
- WAIT:
  - r_addr is held stable until d_ready, because the controller uses r_addr combinationally when the SRAM samples. r_en=0.
  - On d_ready: push r_d, tagged last=(remaining==1), then next_addr++ and remaining--.
  - remaining reaches 0 -> DRAIN; else -> ISSUE.
  - Expected issue-to-d_ready latency is 2 cycles. Maximum throughput is 1 word per 3 cycles.
- DRAIN: wait for FIFO empty and to_consume==0. Then pulse done and go to IDLE.
- Output: to_consume decrements on every out_valid&&out_ready. The FIFO supports push and pop in the same cycle.
- Push into a full FIFO cannot occur because credits are reserved at issue; the verification bench asserts this as a property.
- d_ready while not in WAIT is ignored.
- cmd_valid while busy is not accepted because cmd_ready=0.
- An asynchronous reset mid-burst aborts immediately: FIFO flushed, no done pulse. A d_ready arriving after reset is ignored.

Test Plan:
- Nominal burst: cmd_addr=0x0000, len=4, out_ready=1, controller model with 2-cycle latency -> reads issued at addresses 0..3, one r_en per request, out_last on the 4th word, done pulses once, and r_addr never changes between r_en and d_ready.
- Bank crossing: cmd_addr=0x07FE, len=4 -> r_addr sequence 0x07FE, 0x07FF, 0x0800, 0x0801; data returned in order.
- Backpressure: len=10, out_ready=0 for 30 cycles -> exactly FIFO_DEPTH=4 reads issued and then stall. After out_ready rises, all 10 words are delivered in order and no data is lost.
- Rejects: len=0 -> done next cycle with no r_en. cmd_addr=12280, len=9 -> err pulse, no r_en. cmd_addr=12280, len=8 -> accepted.
- Reset mid-burst: assert reset in WAIT of word 2 of len=6 -> all outputs at reset values immediately, late d_ready ignored, a new command is accepted afterwards.
- Busy command: cmd_valid held during a burst -> cmd_ready=0 and the command is accepted only after returning to IDLE.
